// File: rtl/ad_frame_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : ad_frame_streamer_if
// Brief    : Valid/ready beat stream carrying one averaged channel per beat.
//            Optional m_seq field present when AD_STREAM_SEQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface ad_frame_streamer_if #(
    parameter int DATA_W = 18,
    parameter int NUM_CH = 8
);
    localparam int CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CHAN_W-1:0] m_chan;
    logic              m_last;

`ifdef AD_STREAM_SEQ_EN
    logic [7:0]        m_seq;

    modport master (
        output m_valid, output m_data, output m_chan, output m_last, output m_seq,
        input  m_ready
    );
    modport slave (
        input  m_valid, input m_data, input m_chan, input m_last, input m_seq,
        output m_ready
    );
`else
    modport master (
        output m_valid, output m_data, output m_chan, output m_last,
        input  m_ready
    );
    modport slave (
        input  m_valid, input m_data, input m_chan, input m_last,
        output m_ready
    );
`endif
endinterface

`default_nettype wire

// File: rtl/ad_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : ad_frame_streamer
// Brief    : Averages 2^DECIM_LOG2 frames of NUM_CH samples and streams the
//            result one channel per beat; busy-buffer frames are dropped and
//            counted. Macro AD_STREAM_SEQ_EN adds a per-frame m_seq counter.
// Revision : 1.0 - initial release
// ============================================================================
module ad_frame_streamer #(
    parameter int DATA_W     = 18,
    parameter int NUM_CH     = 8,
    parameter int DECIM_LOG2 = 2
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     en,
    input  wire logic                     frame_valid,
    input  wire logic [NUM_CH*DATA_W-1:0] ch_data,
    ad_frame_streamer_if.master           m,
    output logic                          overrun,
    output logic [7:0]                    ovr_cnt
);
    localparam int ACC_W  = DATA_W + DECIM_LOG2;
    localparam int CNT_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam int CHAN_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  FRAME_MAX = CNT_W'((1 << DECIM_LOG2) - 1);
    localparam logic [CHAN_W-1:0] LAST_CH   = CHAN_W'(NUM_CH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CHAN_W-1:0]        chan_q, chan_d;
    logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                     overrun_q, overrun_d;
    logic [7:0]               ovr_cnt_q, ovr_cnt_d;
    logic signed [ACC_W-1:0]  acc_q [NUM_CH];
    logic signed [ACC_W-1:0]  acc_d [NUM_CH];
    logic [DATA_W-1:0]        buf_q [NUM_CH];
    logic [DATA_W-1:0]        buf_d [NUM_CH];

    logic signed [ACC_W-1:0]  w_sample [NUM_CH];
    logic signed [ACC_W-1:0]  w_sum    [NUM_CH];
    logic [DATA_W-1:0]        w_res    [NUM_CH];

    logic w_fire;
    logic w_complete;
    logic w_last_accept;
    logic w_buf_free;
    logic w_load;

    // Sum includes the current sample so the completing frame loads in the same cycle.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [DATA_W-1:0] w_raw;
        assign w_raw       = ch_data[k*DATA_W +: DATA_W];
        assign w_sample[k] = ACC_W'(w_raw);
        assign w_sum[k]    = (frame_cnt_q == '0) ? w_sample[k] : (acc_q[k] + w_sample[k]);
        assign w_res[k]    = DATA_W'(w_sum[k] >>> DECIM_LOG2);
    end

    assign w_fire        = frame_valid && en;
    assign w_complete    = w_fire && (frame_cnt_q == FRAME_MAX);
    assign w_last_accept = (state_q == SEND) && (chan_q == LAST_CH) && m.m_ready;
    assign w_buf_free    = (state_q == IDLE) || w_last_accept;
    assign w_load        = w_complete && w_buf_free;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;
        ovr_cnt_d   = ovr_cnt_q;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = acc_q[k];
            buf_d[k] = buf_q[k];
        end

        if (!en) begin
            frame_cnt_d = '0;
        end else if (frame_valid) begin
            frame_cnt_d = (frame_cnt_q == FRAME_MAX) ? '0 : frame_cnt_q + 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_d[k] = w_sum[k];
            end
        end

        if (w_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                buf_d[k] = w_res[k];
            end
        end else if (w_complete) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != 8'hFF) begin
                ovr_cnt_d = ovr_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            IDLE: begin
                if (w_load) begin
                    state_d = SEND;
                    chan_d  = '0;
                end
            end
            SEND: begin
                if (m.m_ready) begin
                    if (chan_q == LAST_CH) begin
                        state_d = w_load ? SEND : IDLE;
                        chan_d  = '0;
                    end else begin
                        chan_d = chan_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                chan_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            chan_q      <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= '0;
                buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= acc_d[k];
                buf_q[k] <= buf_d[k];
            end
        end
    end

    assign m.m_valid = (state_q == SEND);
    assign m.m_data  = buf_q[chan_q];
    assign m.m_chan  = chan_q;
    assign m.m_last  = (state_q == SEND) && (chan_q == LAST_CH);
    assign overrun   = overrun_q;
    assign ovr_cnt   = ovr_cnt_q;

`ifdef AD_STREAM_SEQ_EN
    logic [7:0] seq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= '0;
        end else if (w_last_accept) begin
            seq_q <= seq_q + 8'd1;
        end
    end

    assign m.m_seq = seq_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad_frame_streamer.sv
`timescale 1ns/1ps
// Bench for ad_frame_streamer: a pass-through instance (DECIM_LOG2=0) driven from a
// vector table, and an averaging instance (DECIM_LOG2=2) driven by directed sequences.
module tb_ad_frame_streamer;
    localparam int DATA_W = 18;
    localparam int NUM_CH = 8;
    localparam int FW     = NUM_CH * DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en0, fv0, en2, fv2;
    logic [FW-1:0] d0, d2;
    logic          ovr0, ovr2;
    logic [7:0]    cnt0, cnt2;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ad_frame_streamer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) s0 ();
    ad_frame_streamer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) s2 ();

    ad_frame_streamer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DECIM_LOG2(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en0), .frame_valid(fv0), .ch_data(d0),
        .m(s0), .overrun(ovr0), .ovr_cnt(cnt0)
    );
    ad_frame_streamer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DECIM_LOG2(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .frame_valid(fv2), .ch_data(d2),
        .m(s2), .overrun(ovr2), .ovr_cnt(cnt2)
    );

    typedef struct {
        logic fv; int fsel; logic rdy;
        logic e_valid; int e_chan; int e_data; logic e_last;
        logic e_ovr; int e_cnt; logic chk_d;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame A: ch_k = k*1000.  Frame B: ch_k = -(k*100)-1.
    function automatic int fval(int sel, int k);
        return (sel == 0) ? k * 1000 : -(k * 100) - 1;
    endfunction

    function automatic logic [FW-1:0] frame(int sel);
        logic [FW-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(fval(sel, k));
        return f;
    endfunction

    function automatic logic [FW-1:0] mk2(int c0, int c1, int rest);
        logic [FW-1:0] f;
        f[0 +: DATA_W]      = DATA_W'(c0);
        f[DATA_W +: DATA_W] = DATA_W'(c1);
        for (int k = 2; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(rest * k);
        return f;
    endfunction

    function automatic logic [FW-1:0] fill(int v);
        logic [FW-1:0] f;
        for (int k = 0; k < NUM_CH; k++) f[k*DATA_W +: DATA_W] = DATA_W'(v);
        return f;
    endfunction

    task automatic add(input logic fv, input int fsel, input logic rdy, input logic ev,
                       input int ec, input int ed, input logic el, input logic eo,
                       input int en_cnt, input logic cd);
        vec_t v;
        v.fv = fv; v.fsel = fsel; v.rdy = rdy; v.e_valid = ev; v.e_chan = ec;
        v.e_data = ed; v.e_last = el; v.e_ovr = eo; v.e_cnt = en_cnt; v.chk_d = cd;
        vecs.push_back(v);
    endtask

    task automatic pulse2(input logic [FW-1:0] data);
        @(negedge clk); fv2 = 1'b1; d2 = data;
        @(negedge clk); fv2 = 1'b0;
    endtask

    task automatic stream_chk2(input string tag, input int exp[NUM_CH]);
        for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("%s valid c%0d", tag, k), s2.m_valid, 1);
            chk($sformatf("%s chan c%0d", tag, k), s2.m_chan, k);
            chk($sformatf("%s data c%0d", tag, k), $signed(s2.m_data), exp[k]);
            chk($sformatf("%s last c%0d", tag, k), s2.m_last, (k == NUM_CH - 1));
            @(negedge clk);
        end
        chk($sformatf("%s idle after", tag), s2.m_valid, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int exp8[NUM_CH];
        rst_n = 1'b0; en0 = 1'b1; fv0 = 1'b0; d0 = '0; en2 = 1'b1; fv2 = 1'b0; d2 = '0;
        s0.m_ready = 1'b1; s2.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst valid", s0.m_valid, 0);
        chk("rst data", s0.m_data, 0);
        chk("rst chan", s0.m_chan, 0);
        chk("rst last", s0.m_last, 0);
        chk("rst ovr", ovr0, 0);
        chk("rst cnt", cnt0, 0);
        chk("rst valid2", s2.m_valid, 0);
        rst_n = 1'b1;

        // Pass-through: frame A, back-to-back frame B on the last-beat accept, then
        // a stalled frame B with frame A arriving while busy (dropped).
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < NUM_CH; k++)
            add(k == NUM_CH - 1, 1, 1, 1, k, fval(0, k), k == NUM_CH - 1, 0, 0, 1);
        for (int k = 0; k < NUM_CH; k++)
            add(0, 1, 1, 1, k, fval(1, k), k == NUM_CH - 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, fval(1, 0), 0, 0, 0, 1);
        add(0, 1, 0, 1, 0, fval(1, 0), 0, 0, 0, 1);
        add(1, 0, 0, 1, 0, fval(1, 0), 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, fval(1, 0), 0, 1, 1, 1);
        for (int k = 0; k < NUM_CH; k++)
            add(0, 0, 1, 1, k, fval(1, k), k == NUM_CH - 1, 1, 1, 1);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("v%0d valid", i), s0.m_valid, vecs[i].e_valid);
            chk($sformatf("v%0d chan", i), s0.m_chan, vecs[i].e_chan);
            if (vecs[i].chk_d) chk($sformatf("v%0d data", i), $signed(s0.m_data), vecs[i].e_data);
            chk($sformatf("v%0d last", i), s0.m_last, vecs[i].e_last);
            chk($sformatf("v%0d overrun", i), ovr0, vecs[i].e_ovr);
            chk($sformatf("v%0d ovr_cnt", i), cnt0, vecs[i].e_cnt);
            fv0 = vecs[i].fv; d0 = frame(vecs[i].fsel); s0.m_ready = vecs[i].rdy;
        end
        @(negedge clk); fv0 = 1'b0;

        // Averaging: floor of negative sum, mixed channels.
        s2.m_ready = 1'b1;
        pulse2(mk2(-3, 1, -11));
        pulse2(mk2(-3, 2, -11));
        pulse2(mk2(-3, 3, -11));
        chk("avg no early beat", s2.m_valid, 0);
        pulse2(mk2(-2, 5, -11));
        exp8[0] = -3; exp8[1] = 2;
        for (int k = 2; k < NUM_CH; k++) exp8[k] = -11 * k;
        stream_chk2("avgA", exp8);

        // Full-scale averaging: no wrap at either rail.
        repeat (4) pulse2(fill(131071));
        for (int k = 0; k < NUM_CH; k++) exp8[k] = 131071;
        stream_chk2("maxpos", exp8);
        repeat (4) pulse2(fill(-131072));
        for (int k = 0; k < NUM_CH; k++) exp8[k] = -131072;
        stream_chk2("maxneg", exp8);

        // en low discards the partial sum and ignores frames.
        pulse2(fill(1000));
        pulse2(fill(1000));
        @(negedge clk); en2 = 1'b0; fv2 = 1'b1; d2 = fill(5000);
        @(negedge clk); en2 = 1'b1; fv2 = 1'b0;
        pulse2(fill(40));
        pulse2(fill(40));
        chk("en restart no beat", s2.m_valid, 0);
        pulse2(fill(40));
        pulse2(fill(44));
        for (int k = 0; k < NUM_CH; k++) exp8[k] = 41;
        stream_chk2("enlow", exp8);
        chk("avg ovr", ovr2, 0);
        chk("avg ovr_cnt", cnt2, 0);

        // Drop counter saturation: first pulse loads, the other 299 are dropped.
        s0.m_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); fv0 = 1'b1; d0 = frame(1);
        end
        @(negedge clk); fv0 = 1'b0;
        chk("sat ovr_cnt", cnt0, 255);
        chk("sat overrun", ovr0, 1);
        s0.m_ready = 1'b1;
        repeat (12) @(negedge clk);
        chk("sat drained", s0.m_valid, 0);

        // Asynchronous reset mid-burst after beat 3 is accepted.
        @(negedge clk); fv0 = 1'b1; d0 = frame(0);
        @(negedge clk); fv0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-rst chan", s0.m_chan, 3);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("async rst valid", s0.m_valid, 0);
        chk("async rst chan", s0.m_chan, 0);
        chk("async rst ovr", ovr0, 0);
        chk("async rst cnt", cnt0, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst idle %0d", i), s0.m_valid, 0);
        end

        // Two fresh frames after reset.
        for (int f = 0; f < 2; f++) begin
            @(negedge clk); fv0 = 1'b1; d0 = frame(f);
            @(negedge clk); fv0 = 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                chk($sformatf("fr%0d data c%0d", f, k), $signed(s0.m_data), fval(f, k));
`ifdef AD_STREAM_SEQ_EN
                chk($sformatf("fr%0d seq c%0d", f, k), s0.m_seq, f);
`endif
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
